data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 35 +++
 rtl/data_mem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
//   state_t           : responder FSM states
//   DEPTH_WORDS_DEF   : default number of 32-bit words stored
//   WAIT_CYCLES_DEF   : default wait states between acceptance and response
//   WCNT_W            : width of the wait-state counter (covers 0..15)
//   idx_width()       : word-index width for a given depth
//   lane_merge()      : byte-lane merge of new data into an old word
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH_WORDS_DEF = 256;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int WCNT_W          = 4;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage for the data memory responder.
//   clk   : write clock
//   we    : commit a write this edge
//   idx   : word index (shared by read and write)
//   wren  : byte-lane enables for the write
//   wdata : write data
//   rdata : combinational read of the word at idx
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [idx_width(DEPTH_WORDS)-1:0] idx,
  input  logic [3:0]                        wren,
  input  logic [31:0]                       wdata,
  output logic [31:0]                       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= lane_merge(mem[idx], wdata, wren);
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Request/response memory responder with configurable wait states.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_addr          : byte address, word index = req_addr[31:2]
//   req_wren          : byte-lane write enables, 0 = read
//   req_wdata         : write data
//   rsp_valid/ready   : response handshake (valid only in RESP)
//   rsp_rdata         : read data (0 for writes, errors and outside RESP)
//   rsp_err           : word index beyond DEPTH_WORDS
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wren,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] cnt, cnt_nxt;
  logic              accept;
  logic              enter_resp;

  logic [29:0]       idx_p0;
  logic [3:0]        wren_p0;
  logic [31:0]       wdata_p0;

  logic [29:0]       tx_idx;
  logic [3:0]        tx_wren;
  logic [31:0]       tx_wdata;
  logic              tx_in_range;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  logic [31:0]       rdata_p1;
  logic              err_p1;

  logic              unused_addr;

  assign unused_addr = ^req_addr[1:0];
  assign accept      = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT: begin
        if (cnt == WCNT_W'(WAIT_CYCLES - 1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request captured on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= req_addr[31:2];
      wren_p0  <= req_wren;
      wdata_p0 <= req_wdata;
    end
  end

  // With no wait states RESP is entered on the acceptance edge itself, before
  // the capture registers hold the request, so the live request is used then.
  assign tx_idx      = (state == IDLE) ? req_addr[31:2] : idx_p0;
  assign tx_wren     = (state == IDLE) ? req_wren       : wren_p0;
  assign tx_wdata    = (state == IDLE) ? req_wdata      : wdata_p0;
  assign tx_in_range = {2'b00, tx_idx} < DEPTH_WORDS[31:0];
  assign mem_we      = enter_resp && !rst && tx_in_range && (tx_wren != 4'h0);

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (tx_idx[IDX_W-1:0]),
    .wren  (tx_wren),
    .wdata (tx_wdata),
    .rdata (mem_rdata)
  );

  // Stage p1: response latched on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      err_p1   <= !tx_in_range;
      rdata_p1 <= (tx_in_range && tx_wren == 4'h0) ? mem_rdata : 32'h0;
    end
  end

  assign rsp_rdata = rsp_valid ? rdata_p1 : 32'h0;
  assign rsp_err   = rsp_valid && err_p1;

endmodule
